// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver, LSB first.
//
// Samples an asynchronous serial line at mid-bit, checks the start and stop
// bits and hands each good byte to the consumer on a valid/ready handshake.
// The output register holds one byte; a new byte arriving while it is still
// full (and not being taken that cycle) is dropped and flagged.
//
// Parameters
//   CLK_FREQ      clk frequency in Hz
//   BAUD_RATE     line rate in bit/s
//   CLKS_PER_BIT  clk cycles per bit (>= 8), defaults to CLK_FREQ/BAUD_RATE
//
// Ports
//   clk             in   clock
//   rst             in   synchronous, active-high reset
//   UART_RX         in   asynchronous serial line, idle high
//   rx_data         out  received byte, stable while rx_data_valid is high
//   rx_data_valid   out  byte available
//   rx_data_ready   in   consumer accepts the byte
//   rx_frame_error  out  one-cycle pulse: stop bit sampled low
//   rx_overrun      out  one-cycle pulse: good byte dropped, output full
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_error,
    output logic       rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Terminal counts: mid start bit, and one full bit period.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer; both stages reset to the idle (high) level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_next;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_next;
    logic            w_byte_good;   // stop bit sampled high this cycle
    logic            w_stop_bad;    // stop bit sampled low this cycle

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_byte_good    = 1'b0;
        w_stop_bad     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_next   = '0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (r_cnt == HALF_M1) begin
                    // Mid start bit: a high level here means the falling
                    // edge was only a glitch.
                    if (!w_rx_s) begin
                        w_cnt_next     = '0;
                        w_bit_idx_next = '0;
                        w_state_next   = S_DATA;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_rx_s, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    // Leaving at mid stop bit leaves half a bit of margin to
                    // catch a start bit that follows immediately.
                    if (w_rx_s) begin
                        w_byte_good  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) must not decode as a stream of
                // 0x00 frames, so wait for the line to return high first.
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output register and status pulses
    // ------------------------------------------------------------------------
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_error;
    logic       r_overrun;
    logic       w_take;      // current byte leaves this cycle
    logic       w_can_load;  // register is free (or freeing) for a new byte

    assign w_take     = r_valid && rx_data_ready;
    assign w_can_load = !r_valid || w_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data        <= 8'h00;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_stop_bad;
            r_overrun     <= w_byte_good && !w_can_load;
            if (w_byte_good && w_can_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data        = r_data;
    assign rx_data_valid  = r_valid;
    assign rx_frame_error = r_frame_error;
    assign rx_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx - directed bench for uart_rx at 16 clocks per bit.
//
// The stimulus tasks serialize frames onto the line and, at frame start,
// decide from the line-level rules what the receiver must produce: a byte
// for the consumer, a frame-error pulse, or an overrun pulse. A monitor on
// every falling clock edge checks each handshake transfer against the queue
// of expected bytes, byte stability while held, and pulse widths; directed
// checks after each scenario pin counts, latencies and literal values.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB       = 16;
    // Start-edge to valid-rise latency: 2 sync + 1 + CPB/2 + 9*CPB + 1.
    localparam int LAT_NOM   = 2 + 1 + CPB / 2 + 9 * CPB + 1;
    localparam int LAT_LO    = LAT_NOM - 2;
    localparam int LAT_HI    = LAT_NOM + 2;

    logic       clk;
    logic       rst;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_error;
    logic       rx_overrun;

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .UART_RX        (UART_RX),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .rx_data_ready  (rx_data_ready),
        .rx_frame_error (rx_frame_error),
        .rx_overrun     (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // ------------------------------------------------------------------------
    // Model state: bytes the consumer must still receive, expected pulse counts
    // ------------------------------------------------------------------------
    logic [7:0] exp_q[$];
    int exp_fe    = 0;
    int exp_ov    = 0;
    int n_push    = 0;

    // Monitor observations
    int act_fe    = 0;
    int act_ov    = 0;
    int n_rises   = 0;
    int n_xfer    = 0;
    int rise_cyc  = 0;
    int fe_cyc    = 0;
    int ov_cyc    = 0;
    logic [7:0] last_xfer = 8'h00;

    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       pfe = 1'b0;
    logic       pov = 1'b0;
    logic [7:0] pdata = 8'h00;

    always @(negedge clk) begin
        if (rx_data_valid === 1'b1 && pv !== 1'b1) begin
            n_rises++;
            rise_cyc = cyc;
        end
        // A held byte must not change until it is taken.
        if (pv === 1'b1 && pr !== 1'b1 && rx_data_valid === 1'b1)
            chk("held_data_stable", rx_data, pdata);
        // Frames are spaced far apart, so after a transfer valid must drop.
        if (pv === 1'b1 && pr === 1'b1 && rx_data_valid === 1'b1)
            chk("valid_one_cycle", 1, 0);
        if (rx_data_valid === 1'b1 && rx_data_ready === 1'b1) begin
            n_xfer++;
            last_xfer = rx_data;
            if (exp_q.size() == 0) begin
                chk("spurious_byte", rx_data, 32'hFFFF_FFFF);
            end else begin
                chk("xfer_data", rx_data, exp_q.pop_front());
            end
        end
        if (rx_frame_error === 1'b1) begin
            act_fe++;
            fe_cyc = cyc;
            if (pfe === 1'b1) chk("frame_error_width", 2, 1);
        end
        if (rx_overrun === 1'b1) begin
            act_ov++;
            ov_cyc = cyc;
            if (pov === 1'b1) chk("overrun_width", 2, 1);
        end
        pv    = rx_data_valid;
        pr    = rx_data_ready;
        pfe   = rx_frame_error;
        pov   = rx_overrun;
        pdata = rx_data;
    end

    // ------------------------------------------------------------------------
    // Line drivers (all end #1 after a rising edge)
    // ------------------------------------------------------------------------
    int start_cyc = 0;

    task automatic drive_bit(input logic b, input int n);
        UART_RX = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        // Outcome decided from the line rules: bad stop -> frame error;
        // good stop while a byte is still pending and not being taken ->
        // overrun; otherwise the byte reaches the consumer.
        if (!stop_ok) begin
            exp_fe++;
        end else if (exp_q.size() != 0 && !rx_data_ready) begin
            exp_ov++;
        end else begin
            exp_q.push_back(d);
            n_push++;
        end
        start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop_ok, CPB);
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    logic [7:0] lfsr;

    initial begin
        int r0, f0, o0;
        rst           = 1'b1;
        UART_RX       = 1'b1;
        rx_data_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  rx_data,        8'h00);
        chk("rst_valid", rx_data_valid,  0);
        chk("rst_fe",    rx_frame_error, 0);
        chk("rst_ov",    rx_overrun,     0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(10);

        // Single frame 0xA5, ready high.
        send_frame(8'hA5, 1'b1);
        idle(4);
        chk_rng("a5_latency", rise_cyc - start_cyc, LAT_LO, LAT_HI);
        chk("a5_value", last_xfer, 8'hA5);
        chk("a5_rises", n_rises, 1);
        chk("a5_no_err", act_fe + act_ov, 0);

        // Back-to-back frames without idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(4);
        chk("b2b_rises", n_rises, 4);
        chk("b2b_last", last_xfer, 8'h3C);
        chk("b2b_q_empty", exp_q.size(), 0);

        // 3-cycle low glitch, then 0x81.
        r0 = n_rises;
        f0 = act_fe;
        drive_bit(1'b0, 3);
        idle(30);
        chk("glitch_no_valid", n_rises - r0, 0);
        chk("glitch_no_fe", act_fe - f0, 0);
        send_frame(8'h81, 1'b1);
        idle(4);
        chk_rng("g81_latency", rise_cyc - start_cyc, LAT_LO, LAT_HI);
        chk("g81_value", last_xfer, 8'h81);

        // Bad stop bit, break held low, then 0x12.
        r0 = n_rises;
        send_frame(8'h55, 1'b0);
        chk_rng("fe_latency", fe_cyc - start_cyc, LAT_LO, LAT_HI);
        drive_bit(1'b0, 40);
        idle(20);
        chk("fe_count", act_fe, 1);
        chk("fe_no_valid", n_rises - r0, 0);
        send_frame(8'h12, 1'b1);
        idle(4);
        chk("fe_then_12", last_xfer, 8'h12);
        chk("fe_rises", n_rises - r0, 1);

        // Ready low: 0x11 held, 0x22 overruns.
        rx_data_ready = 1'b0;
        o0 = act_ov;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        chk("ov_count", act_ov - o0, 1);
        chk_rng("ov_latency", ov_cyc - start_cyc, LAT_LO, LAT_HI);
        @(negedge clk);
        chk("ov_held_valid", rx_data_valid, 1);
        chk("ov_held_data", rx_data, 8'h11);
        @(posedge clk); #1;
        r0 = n_xfer;
        rx_data_ready = 1'b1;
        idle(3);
        chk("ov_one_xfer", n_xfer - r0, 1);
        chk("ov_xfer_value", last_xfer, 8'h11);
        chk("ov_valid_low", rx_data_valid, 0);

        // Reset in the middle of the data bits, then 0xC3.
        r0 = n_rises;
        f0 = act_fe;
        o0 = act_ov;
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB / 2);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        chk("abort_no_valid", n_rises - r0, 0);
        chk("abort_no_pulses", (act_fe - f0) + (act_ov - o0), 0);
        send_frame(8'hC3, 1'b1);
        idle(4);
        chk_rng("c3_latency", rise_cyc - start_cyc, LAT_LO, LAT_HI);
        chk("c3_value", last_xfer, 8'hC3);

        // Pseudo-random back-to-back stream.
        lfsr = 8'h01;
        for (int k = 0; k < 32; k++) begin
            send_frame(lfsr, 1'b1);
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
        idle(8);

        chk("end_q_empty", exp_q.size(), 0);
        chk("end_rises", n_rises, n_push);
        chk("end_fe", act_fe, exp_fe);
        chk("end_ov", act_ov, exp_ov);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
